// File: rtl/tinker_fetch_queue_if.sv
// tinker_fetch_queue_if
//   Bundles every handshake/bus signal of the Tinker fetch queue.
//   Clock and reset stay plain ports on the module.
//
//   Signal summary (directions seen from the fetch queue, modport master):
//     imem_req_valid  out  fetch request valid
//     imem_req_ready  in   memory accepts request this cycle
//     imem_req_addr   out  byte address of requested instruction
//     imem_rsp_valid  in   response word valid (in request order)
//     imem_rsp_data   in   instruction word
//     redirect_valid  in   core requests fetch restart
//     redirect_pc     in   new fetch address
//     inst_valid      out  inst_data/inst_pc valid to core
//     inst_ready      in   core consumes instruction this cycle
//     inst_data       out  instruction word
//     inst_pc         out  PC of inst_data
//     fq_count        out  occupied FIFO entries
//   Modport slave is the mirror view used by the memory/core side.
interface tinker_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [31:0]   imem_req_addr;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst_data;
    logic [31:0]   inst_pc;
    logic [CW-1:0] fq_count;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc, fq_count,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc, fq_count,
        output inst_ready
    );
endinterface

// File: rtl/tinker_fetch_queue.sv
// tinker_fetch_queue
//   Instruction prefetch stage in front of the Tinker decode logic. Issues
//   in-order fetch requests to a variable-latency instruction memory, buffers
//   returned words with their PCs in a DEPTH-entry FIFO and hands them to the
//   core over valid/ready. A redirect flushes the FIFO and discards responses
//   still in flight.
//
//   Parameters:
//     DEPTH     FIFO entries and maximum requests in flight (power of two, 2..16)
//     RESET_PC  first fetch address after reset
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset
//     fq     tinker_fetch_queue_if.master (memory request/response, redirect,
//            instruction output, fq_count); must be built with the same DEPTH
//
//   Build option:
//     TINKER_FQ_BYPASS_EN  when defined, a response arriving while the FIFO is
//                          empty and nothing is being dropped is presented to
//                          the core combinationally in the same cycle.
module tinker_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h2000
) (
    input  logic                 clk,
    input  logic                 reset,
    tinker_fetch_queue_if.master fq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   in_flight_q, in_flight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   rd_next;
    logic [31:0]     head_data_q, head_data_d;
    logic [31:0]     head_pc_q, head_pc_d;

    logic [31:0]     mem_data [DEPTH];
    logic [31:0]     mem_pc   [DEPTH];

    logic [CW:0]     credit_used;
    logic [31:0]     redirect_aligned;
    logic            req_valid;
    logic            req_fire;
    logic            rsp_keep;
    logic            drop_tick;
    logic            fifo_pop;
    logic            push;
    logic            bypass_hit;
    logic            bypass_take;

    // Requests count against FIFO space together with everything in flight,
    // including responses that will be dropped, so a push can never find the
    // FIFO full.
    assign credit_used      = {1'b0, count_q} + {1'b0, in_flight_q};
    assign req_valid        = reset && !fq.redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign req_fire         = req_valid && fq.imem_req_ready;
    assign redirect_aligned = fq.redirect_pc & 32'hFFFF_FFFC;

    // A response in a redirect cycle belongs to the old stream: it is dropped
    // even when no drop was pending.
    assign rsp_keep  = fq.imem_rsp_valid && (state_q == RUN) && !fq.redirect_valid;
    assign drop_tick = fq.imem_rsp_valid && (state_q == FLUSH);

`ifdef TINKER_FQ_BYPASS_EN
    assign bypass_hit  = rsp_keep && (count_q == '0);
    assign bypass_take = bypass_hit && fq.inst_ready;
`else
    assign bypass_hit  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign fifo_pop = (count_q != '0) && fq.inst_ready;
    assign push     = rsp_keep && !bypass_take;
    assign rd_next  = rd_ptr_q + PW'(1);

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        count_d     = count_q + CW'(push) - CW'(fifo_pop);
        in_flight_d = in_flight_q + CW'(req_fire) - CW'(fq.imem_rsp_valid);
        drop_cnt_d  = drop_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        head_data_d = head_data_q;
        head_pc_d   = head_pc_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (drop_tick) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_next;
        end

        // The head register mirrors the entry at rd_ptr. An incoming word
        // becomes the head when nothing else will remain in front of it.
        if (push && (count_q == CW'(fifo_pop))) begin
            head_data_d = fq.imem_rsp_data;
            head_pc_d   = rsp_pc_q;
        end else if (fifo_pop) begin
            head_data_d = mem_data[rd_next];
            head_pc_d   = mem_pc[rd_next];
        end

        case (state_q)
            RUN:     state_d = RUN;
            FLUSH:   if (drop_cnt_d == '0) state_d = RUN;
            default: state_d = RUN;
        endcase

        // Redirect overrides the FIFO and PCs; everything still in flight
        // after this cycle's response becomes a drop.
        if (fq.redirect_valid) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            drop_cnt_d = in_flight_d;
            state_d    = (in_flight_d != '0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            count_q     <= '0;
            in_flight_q <= '0;
            drop_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            head_data_q <= '0;
            head_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
            drop_cnt_q  <= drop_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            head_data_q <= head_data_d;
            head_pc_q   <= head_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= fq.imem_rsp_data;
            mem_pc[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    assign fq.imem_req_valid = req_valid;
    assign fq.imem_req_addr  = fetch_pc_q;
    assign fq.inst_valid     = (count_q != '0) || bypass_hit;
    assign fq.inst_data      = bypass_hit ? fq.imem_rsp_data : head_data_q;
    assign fq.inst_pc        = bypass_hit ? rsp_pc_q : head_pc_q;
    assign fq.fq_count       = count_q;

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// tb_tinker_fetch_queue
//   Directed bench for tinker_fetch_queue. A fixed-latency in-order memory
//   model answers requests; a queue-based reference model predicts every
//   output on every cycle. Literal checks pin the expected sequences.
module tb_tinker_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tinker_fetch_queue_if #(.DEPTH(DEPTH)) fq_if ();

    tinker_fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(32'h2000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .fq   (fq_if)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int latency = 1;

    logic        ctl_req_ready   = 1'b0;
    logic        ctl_inst_ready  = 1'b0;
    logic        ctl_redirect    = 1'b0;
    logic [31:0] ctl_redirect_pc = 32'h0;

    pend_t       pend[$];
    ent_t        m_fifo[$];
    logic [31:0] m_fetch_pc;
    int          m_inflight;
    int          m_drop;

    logic [31:0] acc_log[$];
    logic [31:0] pop_pc_log[$];
    logic [31:0] pop_data_log[$];
    int          first_valid_cyc;
    int          max_count;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        fq_if.imem_req_ready = 1'b0;
        fq_if.imem_rsp_valid = 1'b0;
        fq_if.imem_rsp_data  = 32'h0;
        fq_if.redirect_valid = 1'b0;
        fq_if.redirect_pc    = 32'h0;
        fq_if.inst_ready     = 1'b0;
        ctl_req_ready  = 1'b0;
        ctl_inst_ready = 1'b0;
        ctl_redirect   = 1'b0;
        pend.delete();
        m_fifo.delete();
        m_fetch_pc = 32'h2000;
        m_inflight = 0;
        m_drop     = 0;
        cyc        = 0;
        acc_log.delete();
        pop_pc_log.delete();
        pop_data_log.delete();
        first_valid_cyc = -1;
        max_count = 0;
        #1;
        check("rst_req_valid", 32'(fq_if.imem_req_valid), 32'h0);
        check("rst_req_addr",  fq_if.imem_req_addr,       32'h2000);
        check("rst_inst_valid", 32'(fq_if.inst_valid),    32'h0);
        check("rst_inst_data", fq_if.inst_data,           32'h0);
        check("rst_inst_pc",   fq_if.inst_pc,             32'h0);
        check("rst_fq_count",  32'(fq_if.fq_count),       32'h0);
        repeat (2) @(posedge clk);
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then
    // advance the model and the memory as the coming edge will.
    task automatic step();
        logic        rsp_v;
        logic [31:0] rsp_a;
        logic [31:0] rsp_d;
        logic        e_req_v;
        logic        e_inst_v;
        logic [31:0] e_data;
        logic [31:0] e_pc;
        logic        byp;
        logic        keep;
        logic        pop;

        @(negedge clk);
        reset = 1'b1;
        rsp_v = 1'b0;
        rsp_a = 32'h0;
        if (pend.size() > 0) begin
            if (pend[0].due <= cyc) begin
                rsp_v = 1'b1;
                rsp_a = pend[0].addr;
            end
        end
        rsp_d = rsp_v ? mem_word(rsp_a) : 32'h0;

        fq_if.imem_req_ready = ctl_req_ready;
        fq_if.imem_rsp_valid = rsp_v;
        fq_if.imem_rsp_data  = rsp_d;
        fq_if.redirect_valid = ctl_redirect;
        fq_if.redirect_pc    = ctl_redirect_pc;
        fq_if.inst_ready     = ctl_inst_ready;
        #1;

        e_req_v = ((m_fifo.size() + m_inflight) < DEPTH) && !ctl_redirect;
`ifdef TINKER_FQ_BYPASS_EN
        byp = (m_fifo.size() == 0) && (m_drop == 0) && rsp_v && !ctl_redirect;
`else
        byp = 1'b0;
`endif
        e_inst_v = (m_fifo.size() > 0) || byp;
        e_data = 32'h0;
        e_pc   = 32'h0;
        if (byp) begin
            e_data = rsp_d;
            e_pc   = rsp_a;
        end else if (m_fifo.size() > 0) begin
            e_data = m_fifo[0].data;
            e_pc   = m_fifo[0].pc;
        end

        check("req_valid",  32'(fq_if.imem_req_valid), 32'(e_req_v));
        check("req_addr",   fq_if.imem_req_addr,       m_fetch_pc);
        check("inst_valid", 32'(fq_if.inst_valid),     32'(e_inst_v));
        check("fq_count",   32'(fq_if.fq_count),       32'(m_fifo.size()));
        if (e_inst_v) begin
            check("inst_data", fq_if.inst_data, e_data);
            check("inst_pc",   fq_if.inst_pc,   e_pc);
        end

        if (fq_if.imem_req_valid && ctl_req_ready) acc_log.push_back(fq_if.imem_req_addr);
        if (fq_if.inst_valid && ctl_inst_ready) begin
            pop_pc_log.push_back(fq_if.inst_pc);
            pop_data_log.push_back(fq_if.inst_data);
        end
        if (fq_if.inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (int'(fq_if.fq_count) > max_count) max_count = int'(fq_if.fq_count);

        keep = rsp_v && (m_drop == 0) && !ctl_redirect;
        if (rsp_v) begin
            void'(pend.pop_front());
            m_inflight--;
            if (m_drop > 0) m_drop--;
        end
        if (ctl_redirect) begin
            m_fifo.delete();
            m_fetch_pc = {ctl_redirect_pc[31:2], 2'b00};
            m_drop = m_inflight;
        end else begin
            pop = e_inst_v && ctl_inst_ready;
            if (pop && !byp) void'(m_fifo.pop_front());
            if (keep && !(byp && ctl_inst_ready)) m_fifo.push_back('{pc: rsp_a, data: rsp_d});
            if (e_req_v && ctl_req_ready) begin
                pend.push_back('{addr: m_fetch_pc, due: cyc + latency});
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_inflight++;
            end
        end
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int hits;

    initial begin
        // Streaming from reset, one-cycle memory, core always ready.
        do_reset();
        latency = 1;
        ctl_req_ready  = 1'b1;
        ctl_inst_ready = 1'b1;
        steps(12);
        check("s1_acc0", acc_log[0], 32'h2000);
        check("s1_acc1", acc_log[1], 32'h2004);
        check("s1_acc2", acc_log[2], 32'h2008);
        check("s1_pop_pc0", pop_pc_log[0], 32'h2000);
        check("s1_pop_pc1", pop_pc_log[1], 32'h2004);
        check("s1_pop_data0", pop_data_log[0], 32'h7A5A_A5A5);
`ifdef TINKER_FQ_BYPASS_EN
        check("s1_first_valid", 32'(first_valid_cyc), 32'd1);
        check("s1_pops", 32'(pop_pc_log.size()), 32'd11);
        check("s1_max_count", 32'(max_count), 32'd0);
`else
        check("s1_first_valid", 32'(first_valid_cyc), 32'd2);
        check("s1_pops", 32'(pop_pc_log.size()), 32'd10);
        check("s1_max_count", 32'(max_count), 32'd1);
`endif

        // Core stalled: fill up, then a single pop frees exactly one credit.
        do_reset();
        latency = 1;
        ctl_req_ready  = 1'b1;
        ctl_inst_ready = 1'b0;
        steps(8);
        check("s2_acc_full", 32'(acc_log.size()), 32'd4);
        check("s2_count_full", 32'(fq_if.fq_count), 32'd4);
        check("s2_req_blocked", 32'(fq_if.imem_req_valid), 32'd0);
        ctl_inst_ready = 1'b1;
        step();
        ctl_inst_ready = 1'b0;
        steps(5);
        check("s2_acc_after_pop", 32'(acc_log.size()), 32'd5);
        check("s2_acc4", acc_log[4], 32'h2010);
        check("s2_count_refill", 32'(fq_if.fq_count), 32'd4);
        check("s2_req_blocked2", 32'(fq_if.imem_req_valid), 32'd0);

        // Redirect with three requests outstanding on a slow memory.
        do_reset();
        latency = 5;
        ctl_req_ready  = 1'b1;
        ctl_inst_ready = 1'b1;
        steps(3);
        ctl_redirect    = 1'b1;
        ctl_redirect_pc = 32'h3002;
        step();
        ctl_redirect = 1'b0;
        step();
        check("s3_count_after_redir", 32'(fq_if.fq_count), 32'd0);
        check("s3_acc_new", acc_log[3], 32'h3000);
        steps(10);
        check("s3_pop_pc0", pop_pc_log[0], 32'h3000);
        check("s3_pop_data0", pop_data_log[0], 32'h6A5A_A5A5);

        // Redirect colliding with a response and a pop, then a second one.
        do_reset();
        latency = 1;
        ctl_req_ready  = 1'b1;
        ctl_inst_ready = 1'b1;
        steps(4);
        ctl_redirect    = 1'b1;
        ctl_redirect_pc = 32'h3800;
        step();
        ctl_redirect_pc = 32'h4000;
        step();
        check("s4_count_after_redir", 32'(fq_if.fq_count), 32'd0);
        ctl_redirect = 1'b0;
        steps(6);
        check("s4_pop_pc2", pop_pc_log[2], 32'h2008);
        check("s4_pop_pc3", pop_pc_log[3], 32'h4000);
        check("s4_acc4", acc_log[4], 32'h4000);
        hits = 0;
        foreach (acc_log[i]) if (acc_log[i] == 32'h3800) hits++;
        foreach (pop_pc_log[i]) if (pop_pc_log[i] == 32'h200C) hits++;
        check("s4_no_stale", 32'(hits), 32'd0);

        // Address wrap at the top of the 32-bit space.
        do_reset();
        latency = 1;
        ctl_req_ready  = 1'b1;
        ctl_inst_ready = 1'b1;
        ctl_redirect    = 1'b1;
        ctl_redirect_pc = 32'hFFFF_FFF8;
        step();
        ctl_redirect = 1'b0;
        steps(6);
        check("s5_acc0", acc_log[0], 32'hFFFF_FFF8);
        check("s5_acc1", acc_log[1], 32'hFFFF_FFFC);
        check("s5_acc2", acc_log[2], 32'h0000_0000);
        check("s5_pop_pc0", pop_pc_log[0], 32'hFFFF_FFF8);
        check("s5_pop_pc2", pop_pc_log[2], 32'h0000_0000);

        // Mixed stalls with redirects landing in FLUSH.
        do_reset();
        latency = 2;
        for (int i = 0; i < 40; i++) begin
            ctl_req_ready   = (i % 3) != 0;
            ctl_inst_ready  = (i % 4) != 1;
            ctl_redirect    = (i == 17) || (i == 19) || (i == 30);
            ctl_redirect_pc = (i == 30) ? 32'h6000 : 32'h5006 + 32'(i);
            step();
        end
        ctl_redirect = 1'b0;
        steps(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tinker_fetch_queue.md
Name: tinker_fetch_queue

Overview:
- Instruction prefetch stage directly upstream of the Tinker core's decode/control logic.
- Issues in-order 32-bit instruction fetch requests to a variable-latency instruction memory port and buffers the returned words with their PCs in a DEPTH-entry FIFO.
- Presents them to the core over a valid/ready interface.
- On a control-flow redirect from the core (branch/call/return), flushes buffered words and discards responses still in flight.

Parameters:
DEPTH, 4, FIFO entries and maximum requests in flight; power of two, 2..16
RESET_PC, 32'h2000, first fetch address after reset

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; asserted when 0
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  byte address of requested instruction
imem_rsp_valid  input  1  response word valid; responses return in request order, never before the cycle after acceptance
imem_rsp_data  input  32  instruction word, little-endian already assembled
redirect_valid  input  1  core requests fetch restart
redirect_pc  input  32  new fetch address
inst_valid  output  1  inst_data/inst_pc valid to core
inst_ready  input  1  core consumes instruction this cycle
inst_data  output  32  instruction word
inst_pc  output  32  PC of inst_data
fq_count  output  $clog2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (reset==0, async): fetch_pc=RESET_PC, FIFO empty, in_flight=0, drop_cnt=0, state=RUN. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, fq_count=0. Reset mid-transaction discards everything; responses arriving after deassertion for pre-reset requests are the memory's responsibility to suppress.
- Request: imem_req_valid=1 when (fq_count + in_flight) < DEPTH and no redirect_valid this cycle; imem_req_addr=fetch_pc. Handshake (valid&&ready): fetch_pc += 4 (32-bit wrap, 32'hFFFFFFFC -> 0), in_flight++. Addr/valid stable while valid && !ready, except redirect.
- Response: imem_rsp_valid with drop_cnt==0: push {data, pc} into FIFO, in_flight--. PC of each entry = address of matching request (tracked by a response-PC register incremented by 4 per accepted response). With drop_cnt>0: discard word, drop_cnt--, in_flight--.
- Output: inst_valid = FIFO non-empty; inst_data/inst_pc = head entry, registered. Pop on inst_valid && inst_ready. Push and pop in same cycle legal at any occupancy; fq_count unchanged. Push never occurs when full (credit rule guarantees it; assertion in bench).
- States: RUN (drop_cnt==0), FLUSH (drop_cnt>0). RUN->FLUSH on redirect with in-flight requests remaining; FLUSH->RUN when last dropped response arrives. Requests to the new PC may issue in FLUSH.
- Redirect (redirect_valid=1), next edge:
  - FIFO emptied, fetch_pc = {redirect_pc[31:2],2'b00}, response-PC = same.
  - drop_cnt = in_flight after this cycle's response (response arriving same cycle is itself dropped if not already).
  - imem_req_valid forced 0 in redirect cycle.
  - A pop in the same cycle completes normally (core consumed it).
  - Back-to-back redirects: each takes latest redirect_pc; drop_cnt recomputed from total in_flight.
- First new request issues the cycle after redirect; earliest inst_valid two cycles after request accept (one-cycle memory).

Optional Feature:
TINKER_FQ_BYPASS_EN
- Defined: when FIFO empty, drop_cnt==0 and imem_rsp_valid, inst_valid/inst_data/inst_pc driven combinationally from the response in that cycle; if inst_ready, word is consumed and not written to FIFO, else written normally.
- Undefined: all outputs registered; response visible the cycle after arrival. fq_count semantics identical in both.

Test Plan:
- Reset release, memory ready, 1-cycle latency, inst_ready=1 -> requests 0x2000,0x2004,0x2008...; inst_pc sequence 0x2000,0x2004 with matching data; no gaps in steady state.
- inst_ready=0, memory always ready -> exactly 4 requests accepted, fq_count reaches 4, imem_req_valid stays 0 until one pop, then one request issues.
- 3 requests in flight (latency 5), redirect_pc=0x3002 -> 3 responses discarded, next request addr 0x3000, first inst_pc 0x3000, fq_count 0 right after redirect.
- Redirect in same cycle as a response and a pop -> pop completes, response dropped, no stale PC appears; second redirect one cycle later to 0x4000 wins.
- fetch_pc redirected to 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order.
- With TINKER_FQ_BYPASS_EN, empty FIFO, inst_ready=1 -> inst_valid same cycle as imem_rsp_valid, fq_count stays 0; without macro -> inst_valid one cycle later.
